// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: muxes core (port 0) and loader/debug (port 1) onto one memory port.
// Define ARB_RR_EN for burst-limited round-robin on ties; default build is fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0Req,
  input  logic              m0Wen,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic [DATA_W-1:0] m0Wdata,
  input  logic [2:0]        m0Size,
  output logic              m0Gnt,
  output logic              m0Rvalid,
  output logic [DATA_W-1:0] m0Rdata,
  input  logic              m1Req,
  input  logic              m1Wen,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic [DATA_W-1:0] m1Wdata,
  input  logic [2:0]        m1Size,
  output logic              m1Gnt,
  output logic              m1Rvalid,
  output logic [DATA_W-1:0] m1Rdata,
  output logic              memWen,
  output logic              memRen,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [2:0]        memSize,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memStall
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  port_e       owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_pend_q, rd_pend_d;
  port_e       rd_tag_q, rd_tag_d;

  logic              tie_win1;
  logic              gnt;
  port_e             sel;
  logic              sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_size;

  // Owner keeps the tie until it has used its burst allowance; fixed mode always favours port 0.
  assign tie_win1 = RR_EN && ((cnt_q < BURST_LIMIT) ? (owner_q == PORT1) : (owner_q == PORT0));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    m0Gnt = 1'b0;
    m1Gnt = 1'b0;
    if (rst && !memStall) begin
      if (m0Req && m1Req) begin
        m1Gnt = tie_win1;
        m0Gnt = !tie_win1;
      end else begin
        m0Gnt = m0Req;
        m1Gnt = m1Req;
      end
    end
  end

  assign gnt       = m0Gnt | m1Gnt;
  assign sel       = m1Gnt ? PORT1 : PORT0;
  assign sel_wen   = (sel == PORT1) ? m1Wen   : m0Wen;
  assign sel_addr  = (sel == PORT1) ? m1Addr  : m0Addr;
  assign sel_wdata = (sel == PORT1) ? m1Wdata : m0Wdata;
  assign sel_size  = (sel == PORT1) ? m1Size  : m0Size;

  assign memWen   = gnt & sel_wen;
  assign memRen   = gnt & ~sel_wen;
  assign memAddr  = gnt ? sel_addr  : '0;
  assign memWdata = gnt ? sel_wdata : '0;
  assign memSize  = gnt ? sel_size  : 3'b000;

  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rd_pend_d = gnt & ~sel_wen;
    rd_tag_d  = rd_tag_q;
    if (gnt) begin
      if (sel == owner_q) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        owner_d = sel;
        cnt_d   = 4'd1;
      end
      if (!sel_wen) rd_tag_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      owner_q   <= PORT0;
      cnt_q     <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= PORT0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  // Gating with rst drops a read response that would land while reset is asserted.
  assign m0Rvalid = rst & rd_pend_q & (rd_tag_q == PORT0);
  assign m1Rvalid = rst & rd_pend_q & (rd_tag_q == PORT1);
  assign m0Rdata  = m0Rvalid ? memRdata : '0;
  assign m1Rdata  = m1Rvalid ? memRdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; checks the fixed-priority build by default, round-robin under ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0Req, m0Wen, m1Req, m1Wen;
  logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
  logic [2:0]  m0Size, m1Size;
  logic        m0Gnt, m0Rvalid, m1Gnt, m1Rvalid;
  logic [31:0] m0Rdata, m1Rdata;
  logic        memWen, memRen;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [2:0]  memSize;
  logic        memStall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0Req(m0Req), .m0Wen(m0Wen), .m0Addr(m0Addr), .m0Wdata(m0Wdata), .m0Size(m0Size),
    .m0Gnt(m0Gnt), .m0Rvalid(m0Rvalid), .m0Rdata(m0Rdata),
    .m1Req(m1Req), .m1Wen(m1Wen), .m1Addr(m1Addr), .m1Wdata(m1Wdata), .m1Size(m1Size),
    .m1Gnt(m1Gnt), .m1Rvalid(m1Rvalid), .m1Rdata(m1Rdata),
    .memWen(memWen), .memRen(memRen), .memAddr(memAddr), .memWdata(memWdata),
    .memSize(memSize), .memRdata(memRdata), .memStall(memStall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0; memStall = 1'b0; memRdata = 32'h0;
    m0Req = 1'b1; m0Wen = 1'b0; m0Addr = 32'h100; m0Wdata = 32'hA0A0_0000; m0Size = 3'b010;
    m1Req = 1'b1; m1Wen = 1'b0; m1Addr = 32'h200; m1Wdata = 32'hB1B1_0000; m1Size = 3'b101;

    // Reset held 3 cycles with both requesting.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("rst_gnt", {m0Gnt, m1Gnt}, 2'b00);
      chk("rst_strobe", {memWen, memRen}, 2'b00);
      chk("rst_rvalid", {m0Rvalid, m1Rvalid}, 2'b00);
      chk("rst_addr", memAddr, 32'h0);
    end

    // First cycle after release: port 0 wins, read of 0x100.
    rst = 1'b1; settle();
    chk("rel_gnt", {m0Gnt, m1Gnt}, 2'b10);
    chk("rel_ren", {memWen, memRen}, 2'b01);
    chk("rel_addr", memAddr, 32'h100);
    chk("rel_size", memSize, 3'b010);

    // Read data one cycle after grant, routed only to port 0.
    tick(); m0Req = 1'b0; m1Req = 1'b0; memRdata = 32'hDEAD_BEEF; settle();
    chk("lat_m0rv", m0Rvalid, 1'b1);
    chk("lat_m0rd", m0Rdata, 32'hDEAD_BEEF);
    chk("lat_m1rv", m1Rvalid, 1'b0);
    chk("lat_m1rd", m1Rdata, 32'h0);
    chk("idle_gnt", {m0Gnt, m1Gnt, memWen, memRen}, 4'b0000);
    tick(); settle();
    chk("lat_done", {m0Rvalid, m1Rvalid}, 2'b00);
    chk("lat_rd0", m0Rdata, 32'h0);

    // UART write from port 1 held off by stall for 5 cycles.
    m1Req = 1'b1; m1Wen = 1'b1; m1Addr = 32'hFFFF_FFFC; m1Wdata = 32'h41; memStall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_gnt", {m0Gnt, m1Gnt}, 2'b00);
      chk("stall_wen", {memWen, memRen}, 2'b00);
      chk("stall_addr", memAddr, 32'h0);
      tick();
    end
    memStall = 1'b0; settle();
    chk("unstall_gnt", {m0Gnt, m1Gnt}, 2'b01);
    chk("unstall_wen", {memWen, memRen}, 2'b10);
    chk("unstall_addr", memAddr, 32'hFFFF_FFFC);
    chk("unstall_wd", memWdata, 32'h41);
    chk("unstall_size", memSize, 3'b101);
    tick(); m1Req = 1'b0; m1Wen = 1'b0; settle();
    chk("wr_noresp", {m0Rvalid, m1Rvalid}, 2'b00);

    // A read granted before a stall still returns during the stall.
    m0Req = 1'b1; m0Addr = 32'h300; settle();
    chk("pre_stall_gnt", m0Gnt, 1'b1);
    tick(); memStall = 1'b1; memRdata = 32'h0000_5A5A; settle();
    chk("stall_rv", m0Rvalid, 1'b1);
    chk("stall_rd", m0Rdata, 32'h0000_5A5A);
    chk("stall_hold", {m0Gnt, memRen}, 2'b00);
    tick(); m0Req = 1'b0; memStall = 1'b0; settle();
    chk("stall_rv_end", m0Rvalid, 1'b0);

    // Alternating back-to-back reads return in grant order with no bubble.
    m0Req = 1'b1; m0Addr = 32'h400; settle();
    chk("alt_g0", {m0Gnt, m1Gnt}, 2'b10);
    tick(); m0Req = 1'b0; m1Req = 1'b1; m1Addr = 32'h500; memRdata = 32'h1111_0000; settle();
    chk("alt_g1", {m0Gnt, m1Gnt}, 2'b01);
    chk("alt_addr1", memAddr, 32'h500);
    chk("alt_rv0", {m0Rvalid, m1Rvalid}, 2'b10);
    chk("alt_rd0", m0Rdata, 32'h1111_0000);
    tick(); m1Req = 1'b0; memRdata = 32'h2222_0000; settle();
    chk("alt_rv1", {m0Rvalid, m1Rvalid}, 2'b01);
    chk("alt_rd1", m1Rdata, 32'h2222_0000);

    // Reset mid-read: port 1 read granted, reset asserts next cycle, response dropped.
    tick(); m1Req = 1'b1; m1Addr = 32'h600; settle();
    chk("mid_gnt", m1Gnt, 1'b1);
    tick(); m1Req = 1'b0; rst = 1'b0; memRdata = 32'h3333_0000; settle();
    chk("mid_rv_n1", m1Rvalid, 1'b0);
    chk("mid_rd_n1", m1Rdata, 32'h0);
    tick(); rst = 1'b1; settle();
    chk("mid_rv_n2", {m0Rvalid, m1Rvalid}, 2'b00);

    // Tie policy from a fresh reset state.
    m0Req = 1'b1; m0Wen = 1'b1; m0Addr = 32'h700; m0Wdata = 32'hC0C0_0001;
    m1Req = 1'b1; m1Wen = 1'b0; m1Addr = 32'h800;
`ifdef ARB_RR_EN
    begin
      logic [8:0] pat;
      pat = 9'b0_1111_0000; // bit i = expected m1Gnt in cycle i
      for (int i = 0; i < 9; i++) begin
        settle();
        chk("rr_gnt", {m0Gnt, m1Gnt}, {~pat[i], pat[i]});
        tick();
      end
    end
`else
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("fp_gnt", {m0Gnt, m1Gnt}, 2'b10);
      chk("fp_wen", {memWen, memRen}, 2'b10);
      chk("fp_wd", memWdata, 32'hC0C0_0001);
      tick();
    end
    m0Req = 1'b0; settle();
    chk("fp_m1_gnt", {m0Gnt, m1Gnt}, 2'b01);
    chk("fp_m1_ren", {memWen, memRen}, 2'b01);
    chk("fp_m1_addr", memAddr, 32'h800);
    tick(); m1Req = 1'b0; memRdata = 32'h4444_0000; settle();
    chk("fp_m1_rv", {m0Rvalid, m1Rvalid}, 2'b01);
    chk("fp_m1_rd", m1Rdata, 32'h4444_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory and its memory-mapped UART window between the core data port (port 0) and a second bus master, the program loader/debug port (port 1). It sits between the requesters and the dmem/uartTx address decode in the SoC. It muxes one request per cycle onto the memory port, returns read data to the issuing requester one cycle later, and holds off all grants while the memory side reports a stall (UART FIFO full).

## Interface
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive grants to one owner while the other waits (round-robin mode only); legal range 1..15
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- m0Req, m1Req  in  1  request valid; held with its fields stable until the matching gnt is sampled high
- m0Wen, m1Wen  in  1  1 = write, 0 = read
- m0Addr, m1Addr  in  ADDR_W  byte address
- m0Wdata, m1Wdata  in  DATA_W  write data
- m0Size, m1Size  in  3  access size/sign code, passed through untouched
- m0Gnt, m1Gnt  out  1  transfer accepted this cycle (combinational, one-hot or zero)
- m0Rvalid, m1Rvalid  out  1  read data valid, one cycle after a read grant
- m0Rdata, m1Rdata  out  DATA_W  read data, valid when Rvalid
- memWen, memRen  out  1  memory write/read strobes
- memAddr, memWdata  out  ADDR_W/DATA_W  muxed address/data
- memSize  out  3  muxed size
- memRdata  in  DATA_W  memory read data, valid one cycle after memRen
- memStall  in  1  memory side cannot accept (UART FIFO full); no grant while high

## Operation
- State: owner (1 bit, last granted port), cnt (4 bits, consecutive grants to owner), rdPend (1 bit), rdTag (1 bit).
- Grant decision, only when rst=1 and memStall=0:
  - only one req high → that port granted.
  - both high → winner by policy (see Configuration).
  - no req → no grant; owner/cnt unchanged.
- Granted port's Wen/Addr/Wdata/Size drive mem*; memWen = gnt & Wen, memRen = gnt & !Wen. With no grant, memWen = memRen = 0, and memAddr/memWdata/memSize are 0.
- On grant to port p: if p == owner then cnt ← min(cnt+1, 15) else owner ← p, cnt ← 1.
- Read grant sets rdPend ← 1, rdTag ← p on the next edge; otherwise rdPend ← 0.
- mPRvalid = rdPend & (rdTag == P); mPRdata = memRdata when its Rvalid is high, else 0.
- Writes produce no response; the grant cycle is the completion.
- The arbiter does not interpret addresses; the UART window (0xFFFF_FFFC) is decoded downstream.

## Timing
- Grant is combinational in the request cycle. Zero-wait throughput: one transfer per cycle.
- Read latency: grant at cycle N, Rvalid/Rdata at cycle N+1. Back-to-back reads from alternating ports return in grant order, with no bubble.
- memStall high in cycle N: no gnt and no mem strobes in N. The request stays pending. Any rdPend from N−1 still completes in N.
- Reset (rst=0 at an edge): owner ← 0, cnt ← 0, rdPend ← 0, rdTag ← 0. While rst=0, all gnt, Rvalid and mem strobes are forced 0 and all data outputs are 0. A read granted in the cycle before reset asserts is dropped: no Rvalid after reset.
- Simultaneous new request and Rvalid to the same port are independent; both are allowed in the same cycle.

## Configuration
- ARB_RR_EN defined: burst-limited round-robin. On a tie, owner wins if cnt < MAX_BURST, otherwise the other port wins; cnt resets to 1 on owner switch.
- ARB_RR_EN undefined: fixed priority, port 0 (core) always wins a tie. owner/cnt are still tracked but do not affect the decision. Port 1 can starve; that is acceptable for loader use with the core held idle.

## Test plan
- Reset: rst=0 for 3 cycles with both req high → gnt=00, memWen=memRen=0, Rvalid=0. First cycle after release with both req → m0Gnt=1.
- Read latency: m0 read Addr=0x100, memRdata=0xDEADBEEF on the next cycle → m0Rvalid=1 and m0Rdata=0xDEADBEEF exactly 1 cycle after grant; m1Rvalid stays 0.
- Stall: m1 write to 0xFFFF_FFFC with memStall=1 for 5 cycles → no m1Gnt, memWen=0. Grant and memWen=1 in the cycle memStall drops.
- Round-robin (ARB_RR_EN, MAX_BURST=4): both req continuous → grant pattern 0,0,0,0,1,1,1,1,0…
- Fixed priority (no macro): both req continuous for 10 cycles → m0Gnt=1 every cycle, m1Gnt=0. After m0Req drops, m1Gnt=1 in the same cycle.
- Reset mid-read: m1 read granted at cycle N, rst=0 at edge N+1 → m1Rvalid=0 in N+1 and after.
